// File: rtl/ftb_update_unit.sv
// FTB update engine: folds resolved-branch feedback into the FTB SRAM with a
// read-modify-write, compressing fallthrough/target against the block start PC.
module ftb_update_unit #(
    parameter int XLEN  = 64,
    parameter int IDX_W = 9,
    parameter int TAG_W = 12,
    parameter int WAYS  = 2,
    parameter int FT_W  = 4,
    parameter int TAR_W = 12,
    parameter int OFS_W = 2,
    parameter int CTR_W = 2,
    localparam int ENTRY_W = TAG_W + 1 + 1 + FT_W + OFS_W + TAR_W + 3 + CTR_W,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [XLEN-1:0]         upd_start,
    input  logic [XLEN-1:0]         upd_fallthru,
    input  logic [XLEN-1:0]         upd_target,
    input  logic                    upd_taken,
    input  logic [2:0]              upd_brtype,
    output logic                    sram_rd_en,
    output logic [IDX_W-1:0]        sram_rd_idx,
    input  logic [WAYS*ENTRY_W-1:0] sram_rd_data,
    output logic                    sram_wr_en,
    output logic [IDX_W-1:0]        sram_wr_idx,
    output logic [WAY_W-1:0]        sram_wr_way,
    output logic [ENTRY_W-1:0]      sram_wr_data,
    output logic                    upd_done,
    output logic                    upd_hit,
    output logic                    upd_drop,
    output logic [15:0]             drop_cnt
);
    localparam int HW = XLEN - FT_W - 1;
    localparam int DW = XLEN - TAR_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_WRITE} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             vld;
        logic             carry;
        logic [FT_W-1:0]  ft;
        logic [OFS_W-1:0] ofs;
        logic [TAR_W-1:0] tar;
        logic [2:0]       brtype;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    state_t             r_state;
    logic [WAY_W-1:0]   r_rr;
    logic [15:0]        r_drop_cnt;
    logic               r_drop;
    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic               r_carry;
    logic [FT_W-1:0]    r_ft;
    logic [OFS_W-1:0]   r_ofs;
    logic [TAR_W-1:0]   r_tar;
    logic [2:0]         r_brtype;
    logic               r_taken;
    logic               r_wr_en;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [WAY_W-1:0]   r_wr_way;
    entry_t             r_wr_data;
    logic               r_done;
    logic               r_hit;

    logic [HW-1:0]      w_sh, w_fh;
    logic [DW-1:0]      w_d;
    logic               w_carry, w_ft_ok, w_ofs_ok, w_comp, w_acc;
    entry_t             w_way [WAYS];
    logic               w_hit, w_inv, w_same;
    logic [WAY_W-1:0]   w_hit_way, w_inv_way, w_way_sel;
    logic [CTR_W-1:0]   w_ctr_init, w_ctr_move;
    entry_t             w_new;
    logic               w_unused;

    assign w_unused = ^{upd_start[0], upd_fallthru[0], upd_target[0]};

    // Fallthrough must sit in the same or next aligned block; target offset must fit OFS_W signed.
    assign w_sh     = upd_start[XLEN-1:FT_W+1];
    assign w_fh     = upd_fallthru[XLEN-1:FT_W+1];
    assign w_carry  = (w_fh == w_sh + HW'(1));
    assign w_ft_ok  = (w_fh == w_sh) | w_carry;
    assign w_d      = upd_target[XLEN-1:TAR_W+1] - upd_start[XLEN-1:TAR_W+1];
    assign w_ofs_ok = (&w_d[DW-1:OFS_W-1]) | ~(|w_d[DW-1:OFS_W-1]);
    assign w_comp   = w_ft_ok & w_ofs_ok;

    assign upd_ready   = (r_state == S_IDLE);
    assign w_acc       = upd_valid & upd_ready;
    assign sram_rd_en  = w_acc & w_comp;
    assign sram_rd_idx = sram_rd_en ? upd_start[IDX_W:1] : '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign w_way[w] = entry_t'(sram_rd_data[w*ENTRY_W +: ENTRY_W]);
    end

    // Scan high to low so the lowest matching / invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_way[w].vld && (w_way[w].tag == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_way[w].vld) begin
                w_inv     = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    assign w_same = (w_way[w_hit_way].carry  == r_carry) &&
                    (w_way[w_hit_way].ft     == r_ft)    &&
                    (w_way[w_hit_way].ofs    == r_ofs)   &&
                    (w_way[w_hit_way].tar    == r_tar)   &&
                    (w_way[w_hit_way].brtype == r_brtype);

    assign w_ctr_init = r_taken ? CTR_W'(1 << (CTR_W - 1)) : CTR_W'((1 << (CTR_W - 1)) - 1);

    always_comb begin
        w_ctr_move = w_way[w_hit_way].ctr;
        if (r_taken) begin
            if (!(&w_way[w_hit_way].ctr)) w_ctr_move = w_way[w_hit_way].ctr + CTR_W'(1);
        end else begin
            if (|w_way[w_hit_way].ctr) w_ctr_move = w_way[w_hit_way].ctr - CTR_W'(1);
        end
    end

    always_comb begin
        w_new        = '0;
        w_new.tag    = r_tag;
        w_new.vld    = 1'b1;
        w_new.carry  = r_carry;
        w_new.ft     = r_ft;
        w_new.ofs    = r_ofs;
        w_new.tar    = r_tar;
        w_new.brtype = r_brtype;
        w_new.ctr    = (w_hit && w_same) ? w_ctr_move : w_ctr_init;
    end

    assign w_way_sel = w_hit ? w_hit_way : (w_inv ? w_inv_way : r_rr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_drop_cnt <= '0;
            r_drop     <= 1'b0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_carry    <= 1'b0;
            r_ft       <= '0;
            r_ofs      <= '0;
            r_tar      <= '0;
            r_brtype   <= '0;
            r_taken    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_way   <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (w_comp) begin
                            r_idx    <= upd_start[IDX_W:1];
                            r_tag    <= upd_start[IDX_W+TAG_W:IDX_W+1];
                            r_carry  <= w_carry;
                            r_ft     <= upd_fallthru[FT_W:1];
                            r_ofs    <= w_d[OFS_W-1:0];
                            r_tar    <= upd_target[TAR_W:1];
                            r_brtype <= upd_brtype;
                            r_taken  <= upd_taken;
                            r_state  <= S_MERGE;
                        end else begin
                            r_drop <= 1'b1;
                            if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end
                end
                S_MERGE: begin
                    r_wr_en   <= 1'b1;
                    r_done    <= 1'b1;
                    r_hit     <= w_hit;
                    r_wr_idx  <= r_idx;
                    r_wr_way  <= w_way_sel;
                    r_wr_data <= w_new;
                    if (!w_hit && !w_inv)
                        r_rr <= (r_rr == WAY_W'(WAYS - 1)) ? '0 : r_rr + WAY_W'(1);
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr_en   <= 1'b0;
                    r_done    <= 1'b0;
                    r_hit     <= 1'b0;
                    r_wr_idx  <= '0;
                    r_wr_way  <= '0;
                    r_wr_data <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_wr_en   = r_wr_en;
    assign sram_wr_idx  = r_wr_idx;
    assign sram_wr_way  = r_wr_way;
    assign sram_wr_data = r_wr_data;
    assign upd_done     = r_done;
    assign upd_hit      = r_hit;
    assign upd_drop     = r_drop;
    assign drop_cnt     = r_drop_cnt;

endmodule
